// File: rtl/display_share_arbiter_if.sv
// Display-share bundle between two requesters and the arbiter.
// Carries both request/value pairs towards the arbiter and the grants,
// digit outputs and busy flag back out to the requesters/display driver.
//
// Signals:
//   req0/req1  : level requests, held high while the display is wanted
//   val0/val1  : 16-bit digit values, [15:12] leftmost ... [3:0] rightmost
//   gnt0/gnt1  : registered ownership flags, never both high
//   hex3..hex0 : registered digits for the multiplexed display driver
//   busy       : gnt0 | gnt1
//
// Modports:
//   master : requester side, drives req/val and observes grants and digits
//   slave  : arbiter side
interface display_share_arbiter_if;
  logic        req0;
  logic [15:0] val0;
  logic        req1;
  logic [15:0] val1;
  logic        gnt0;
  logic        gnt1;
  logic [3:0]  hex3;
  logic [3:0]  hex2;
  logic [3:0]  hex1;
  logic [3:0]  hex0;
  logic        busy;

  modport master (
    output req0, val0, req1, val1,
    input  gnt0, gnt1, hex3, hex2, hex1, hex0, busy
  );

  modport slave (
    input  req0, val0, req1, val1,
    output gnt0, gnt1, hex3, hex2, hex1, hex0, busy
  );
endinterface

// File: rtl/display_share_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between two requesters.
// Latency: grant and digits update one clk edge after the request/value is sampled.
// Backpressure: none; a requester waits (level req held) until its grant arrives.
//
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset; outputs return to reset values at once
//   bus    : display_share_arbiter_if.slave (req0/val0, req1/val1 in;
//            gnt0, gnt1, hex3..hex0, busy out)
//
// Parameters:
//   DWELL_CYCLES : minimum cycles an owner keeps the display while the other requests
//   CNT_W        : dwell counter width, 2**CNT_W must exceed DWELL_CYCLES
//
// Configuration macro DISP_ARB_HOLD_LAST_EN:
//   defined   : on return to IDLE the digits keep the last owner's value
//   undefined : on return to IDLE the digits are cleared to 16'h0000
//   Grants, FSM and timing are the same in both builds.
module display_share_arbiter #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  display_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL = CNT_W'(DWELL_CYCLES);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             expired;
  // 1 after reset so that requester 0 wins the very first tie.
  logic             last_owner;

  logic             gnt0_d;
  logic             gnt1_d;
  logic             busy_d;
  logic [15:0]      hex_d;

  logic             gnt0_q;
  logic             gnt1_q;
  logic             busy_q;
  logic [15:0]      hex_q;

  // Saturating count of owned cycles completed, including the current one.
  // The owner's share is used up once this reaches DWELL, so an owner that is
  // contended from its first cycle holds the display for exactly DWELL cycles.
  always_comb begin
    cnt_inc = (cnt == DWELL) ? cnt : cnt + CNT_W'(1);
    expired = (cnt_inc == DWELL);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // A release always wins over dwell expiry, and a released display goes
  // straight to the waiting requester without passing through IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_nxt = last_owner ? OWN0 : OWN1;
        end else if (bus.req0) begin
          state_nxt = OWN0;
        end else if (bus.req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          state_nxt = bus.req1 ? OWN1 : IDLE;
        end else if (expired && bus.req1) begin
          state_nxt = OWN1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_nxt = bus.req0 ? OWN0 : IDLE;
        end else if (expired && bus.req0) begin
          state_nxt = OWN0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // Outputs are computed from the next state and registered, so grants swap
  // on a single edge and the digits always belong to the current grant holder.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0_d = (state_nxt == OWN0);
    gnt1_d = (state_nxt == OWN1);
    busy_d = gnt0_d | gnt1_d;
    case (state_nxt)
      OWN0:    hex_d = bus.val0;
      OWN1:    hex_d = bus.val1;
`ifdef DISP_ARB_HOLD_LAST_EN
      default: hex_d = hex_q;
`else
      default: hex_d = 16'h0000;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      busy_q <= 1'b0;
      hex_q  <= 16'h0000;
    end else begin
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      busy_q <= busy_d;
      hex_q  <= hex_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Dwell counter and round-robin history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= 1'b1;
    end else if (state == OWN0) begin
      last_owner <= 1'b0;
    end else if (state == OWN1) begin
      last_owner <= 1'b1;
    end
  end

  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.busy = busy_q;
  assign bus.hex3 = hex_q[15:12];
  assign bus.hex2 = hex_q[11:8];
  assign bus.hex1 = hex_q[7:4];
  assign bus.hex0 = hex_q[3:0];

endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter with DWELL_CYCLES=8, CNT_W=4.
// Directed table, hand-written corner sequences, then randomized traffic
// against a behavioural model of owner / owned-cycle count / last owner.
module tb_display_share_arbiter;

  localparam int DWELL = 8;
`ifdef DISP_ARB_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk;
  logic rst_n;

  display_share_arbiter_if bus();

  display_share_arbiter #(
    .DWELL_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: -1 = nobody owns the display.
  int          m_owner;
  int          m_held;
  int          m_last;
  logic [15:0] m_hex;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_hex();
    return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 1;
    m_hex   = 16'h0000;
  endtask

  // One clock edge of the arbitration rules, using the inputs present at the edge.
  task automatic model_step();
    int nxt;
    bit mine;
    bit other;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (bus.req0 && bus.req1) nxt = (m_last == 0) ? 1 : 0;
      else if (bus.req0)        nxt = 0;
      else if (bus.req1)        nxt = 1;
    end else begin
      mine  = (m_owner == 0) ? bus.req0 : bus.req1;
      other = (m_owner == 0) ? bus.req1 : bus.req0;
      m_held++;
      if (!mine)                           nxt = other ? 1 - m_owner : -1;
      else if (m_held >= DWELL && other)   nxt = 1 - m_owner;
    end
    if (nxt != m_owner) m_held = 0;
    if (nxt >= 0) begin
      m_last = nxt;
      m_hex  = (nxt == 0) ? bus.val0 : bus.val1;
    end else if (!HOLD) begin
      m_hex = 16'h0000;
    end
    m_owner = nxt;
  endtask

  // Advance one edge and land 1 time unit after it for sampling.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input bit r0, input bit r1, input logic [15:0] v0, input logic [15:0] v1);
    bus.req0 = r0;
    bus.req1 = r1;
    bus.val0 = v0;
    bus.val1 = v1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 16'h0, 16'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_model(input string name);
    chk({name, "_gnt0"}, 32'(bus.gnt0), 32'(m_owner == 0));
    chk({name, "_gnt1"}, 32'(bus.gnt1), 32'(m_owner == 1));
    chk({name, "_busy"}, 32'(bus.busy), 32'(m_owner >= 0));
    chk({name, "_hex"},  32'(dut_hex()), 32'(m_hex));
  endtask

  typedef struct {
    bit          r0;
    bit          r1;
    logic [15:0] v0;
    logic [15:0] v1;
    bit          e0;
    bit          e1;
    logic [15:0] eh;
  } vec_t;

  vec_t tbl[9];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c;
    int w;
    bit phase2;

    tbl[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234};
    tbl[1] = '{1'b1, 1'b0, 16'h5678, 16'h0000, 1'b1, 1'b0, 16'h5678};
    tbl[2] = '{1'b0, 1'b0, 16'h5678, 16'h0000, 1'b0, 1'b0, HOLD ? 16'h5678 : 16'h0000};
    tbl[3] = '{1'b0, 1'b1, 16'h5678, 16'hCAFE, 1'b0, 1'b1, 16'hCAFE};
    tbl[4] = '{1'b0, 1'b0, 16'h5678, 16'hCAFE, 1'b0, 1'b0, HOLD ? 16'hCAFE : 16'h0000};
    tbl[5] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h1111};
    tbl[6] = '{1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, 16'h2222};
    tbl[7] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, 16'h2222};
    tbl[8] = '{1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, HOLD ? 16'h2222 : 16'h0000};

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 16'h0, 16'h0);
    model_reset();
    #1;
    chk("reset_gnt0", 32'(bus.gnt0), 32'd0);
    chk("reset_gnt1", 32'(bus.gnt1), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hex",  32'(dut_hex()), 32'h0000);
    do_reset();

    // Directed table: one edge per row.
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].r0, tbl[i].r1, tbl[i].v0, tbl[i].v1);
      tick();
      chk($sformatf("tbl%0d_gnt0", i), 32'(bus.gnt0), 32'(tbl[i].e0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(bus.gnt1), 32'(tbl[i].e1));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].e0 | tbl[i].e1));
      chk($sformatf("tbl%0d_hex", i),  32'(dut_hex()), 32'(tbl[i].eh));
    end

    // Tie from reset: req0 first, then 8 owned cycles each way.
    do_reset();
    set_in(1'b1, 1'b1, 16'hAAAA, 16'h5555);
    tick();
    chk("tie_first_gnt0", 32'(bus.gnt0), 32'd1);
    c = 0;
    while (bus.gnt0 && c < 20) begin c++; tick(); end
    chk("tie_own0_cycles", 32'(c), 32'd8);
    chk("tie_then_gnt1", 32'(bus.gnt1), 32'd1);
    chk("tie_swap_gnt0_low", 32'(bus.gnt0), 32'd0);
    c = 0;
    while (bus.gnt1 && c < 20) begin c++; tick(); end
    chk("tie_own1_cycles", 32'(c), 32'd8);
    chk("tie_back_gnt0", 32'(bus.gnt0), 32'd1);

    // Early release at owned cycle 3 while the other side waits.
    do_reset();
    set_in(1'b1, 1'b1, 16'hAAAA, 16'h5555);
    tick();
    tick();
    tick();
    chk("early_still_gnt0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 1'b0;
    tick();
    chk("early_gnt1", 32'(bus.gnt1), 32'd1);
    chk("early_gnt0", 32'(bus.gnt0), 32'd0);
    chk("early_hex",  32'(dut_hex()), 32'h5555);

    // Asynchronous reset in the middle of OWN1.
    bus.val1 = 16'hBEEF;
    tick();
    chk("own1_hex_beef", 32'(dut_hex()), 32'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_hex",  32'(dut_hex()), 32'h0000);
    set_in(1'b0, 1'b0, 16'h0, 16'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle_gnt0", 32'(bus.gnt0), 32'd0);
    chk("post_rst_idle_gnt1", 32'(bus.gnt1), 32'd0);
    set_in(1'b1, 1'b1, 16'h0F0F, 16'hF0F0);
    tick();
    chk("post_rst_tie_gnt0", 32'(bus.gnt0), 32'd1);
    chk("post_rst_tie_hex",  32'(dut_hex()), 32'h0F0F);

    // Randomized traffic: req0 held high first, then both requesters random.
    do_reset();
    w = 0;
    bus.req0 = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      phase2 = (n >= 1500);
      if ($urandom_range(9) == 0) bus.req1 = ~bus.req1;
      if (phase2 && $urandom_range(5) == 0) bus.req0 = ~bus.req0;
      if (!phase2) bus.req0 = 1'b1;
      bus.val0 = 16'($urandom);
      bus.val1 = 16'($urandom);
      if (!phase2 && bus.req1 && !bus.gnt1) w++;
      if (!bus.req1) w = 0;
      tick();
      chk_model($sformatf("rnd%0d", n));
      if (bus.gnt0 && bus.gnt1) chk("rnd_mutex", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      if (!phase2 && bus.gnt1 && w > 0) begin
        chk("rnd_no_starve", 32'(w <= 9), 32'd1);
        w = 0;
      end else if (w > 9) begin
        chk("rnd_starve_bound", 32'(w), 32'd9);
        w = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
